// File: rtl/ram64_arbiter.sv
// Round-robin arbiter/sequencer sharing one ram64 (sync write, comb read) between two requesters.
// Optional power-up clear sweep of all 64 words is enabled by defining RAM64_ARB_CLEAR_EN.
module ram64_arbiter #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [WIDTH-1:0]  din0,
  input  logic              we0,
  output logic              ack0,
  output logic [WIDTH-1:0]  dout0,
  input  logic              req1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]  din1,
  input  logic              we1,
  output logic              ack1,
  output logic [WIDTH-1:0]  dout1,
  output logic [AWIDTH-1:0] mem_address,
  output logic [WIDTH-1:0]  mem_in,
  output logic              mem_load,
  input  logic [WIDTH-1:0]  mem_out,
  output logic              busy
);

  // Handshake: a requester raises reqN with addrN/dinN/weN stable and holds
  // them until ackN pulses for one cycle; reqN still high in the IDLE cycle
  // after the ack is a fresh request.
`ifdef RAM64_ARB_CLEAR_EN
  typedef enum logic [1:0] {INIT, IDLE, ACCESS, ACK} state_t;
  localparam state_t RESET_STATE = INIT;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state, state_next;
  logic   gnt;
  logic   last_grant;
  logic   grant_sel;
  logic   any_req;

  logic [AWIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_din;
  logic              sel_we;

`ifdef RAM64_ARB_CLEAR_EN
  logic [AWIDTH-1:0] cnt;
`endif

  assign any_req  = req0 | req1;
  assign sel_addr = gnt ? addr1 : addr0;
  assign sel_din  = gnt ? din1  : din0;
  assign sel_we   = gnt ? we1   : we0;

  // Contention goes to whoever was not served last.
  always_comb begin
    grant_sel = 1'b0;
    if (req0 && req1) grant_sel = ~last_grant;
    else if (req1)    grant_sel = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    mem_address = '0;
    mem_in      = '0;
    mem_load    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = ACCESS;
      end
      ACCESS: begin
        mem_address = sel_addr;
        mem_in      = sel_din;
        mem_load    = sel_we;
        state_next  = ACK;
      end
      ACK: begin
        state_next = IDLE;
      end
`ifdef RAM64_ARB_CLEAR_EN
      INIT: begin
        mem_address = cnt;
        mem_load    = 1'b1;
        if (cnt == '1) state_next = IDLE;
      end
`endif
      default: state_next = RESET_STATE;
    endcase
    // Reset kills the RAM strobe at once so an in-flight write is aborted.
    if (reset) begin
      mem_address = '0;
      mem_in      = '0;
      mem_load    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      dout0      <= '0;
      dout1      <= '0;
    end else begin
      ack0 <= (state == ACCESS) && !gnt;
      ack1 <= (state == ACCESS) &&  gnt;
      if (state == IDLE && any_req) begin
        gnt        <= grant_sel;
        last_grant <= grant_sel;
      end
      if (state == ACCESS && !sel_we) begin
        if (gnt) dout1 <= mem_out;
        else     dout0 <= mem_out;
      end
    end
  end

`ifdef RAM64_ARB_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               cnt <= '0;
    else if (state == INIT)  cnt <= cnt + 1'b1;
  end

  assign busy = (state == INIT);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_ram64_arbiter.sv
// Directed self-checking bench for ram64_arbiter with a behavioural ram64 attached.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ram64_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, we0, ack0;
  logic [5:0]  addr0;
  logic [15:0] din0, dout0;
  logic        req1, we1, ack1;
  logic [5:0]  addr1;
  logic [15:0] din1, dout1;
  logic [5:0]  mem_address;
  logic [15:0] mem_in, mem_out;
  logic        mem_load;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] ram [64];

  ram64_arbiter #(.WIDTH(16), .AWIDTH(6)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .din0(din0), .we0(we0), .ack0(ack0), .dout0(dout0),
    .req1(req1), .addr1(addr1), .din1(din1), .we1(we1), .ack1(ack1), .dout1(dout1),
    .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out),
    .busy(busy)
  );

  // clock / ram64 model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;
  assign mem_out = ram[mem_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
`ifdef RAM64_ARB_CLEAR_EN
    begin
      int n = 0;
      while (busy && n < 200) begin
        n++;
        @(negedge clk);
      end
      check("busy_cycles", n, 64);
    end
`endif
  endtask

  // One access on port p; checks ack latency, pin values and single-pulse ack.
  task automatic do_access(input bit p, input logic [5:0] a, input logic [15:0] d,
                           input logic w);
    if (!p) begin req0 = 1'b1; addr0 = a; din0 = d; we0 = w; end
    else    begin req1 = 1'b1; addr1 = a; din1 = d; we1 = w; end
    @(negedge clk);
    check("acc_load", mem_load, w);
    check("acc_addr", mem_address, a);
    if (w) check("acc_din", mem_in, d);
    check("acc_noack", {ack1, ack0}, 2'b00);
    @(negedge clk);
    check("ack_pulse", {ack1, ack0}, p ? 2'b10 : 2'b01);
    check("ack_load", mem_load, 1'b0);
    check("ack_addr", mem_address, 6'd0);
    if (!p) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
    check("ack_single", {ack1, ack0}, 2'b00);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; din0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; din1 = 0;
    @(negedge clk);
    check("rst_ack", {ack1, ack0}, 2'b00);
    check("rst_dout0", dout0, 16'h0000);
    check("rst_dout1", dout1, 16'h0000);
    check("rst_mem", {mem_load, mem_address, mem_in}, 23'd0);
`ifdef RAM64_ARB_CLEAR_EN
    check("rst_busy", busy, 1'b1);
`else
    check("rst_busy", busy, 1'b0);
`endif
    reset_dut();
    check("idle_mem", {mem_load, mem_address, mem_in}, 23'd0);
    check("idle_busy", busy, 1'b0);

    // Test 1: write then read on port 0
    do_access(0, 6'd3, 16'h1234, 1'b1);
    do_access(0, 6'd3, 16'h0000, 1'b0);
    check("t1_dout0", dout0, 16'h1234);
    check("t1_dout1", dout1, 16'h0000);

    // Preload via port 1 so last_grant=1 and port 0 wins the next tie
    do_access(1, 6'd5, 16'h0005, 1'b1);
    do_access(1, 6'd6, 16'h0006, 1'b1);

    // Test 2: simultaneous requests
    req0 = 1'b1; addr0 = 6'd5; we0 = 1'b0;
    req1 = 1'b1; addr1 = 6'd6; we1 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("t2_ack", {ack1, ack0}, {(i == 5), (i == 2)});
      if (i == 2) req0 = 1'b0;
      if (i == 5) req1 = 1'b0;
    end
    check("t2_dout0", dout0, 16'h0005);
    check("t2_dout1", dout1, 16'h0006);
    @(negedge clk);

    // Test 3: both held high, grants alternate 0,1,0,1
    req0 = 1'b1; addr0 = 6'd6; we0 = 1'b0;
    req1 = 1'b1; addr1 = 6'd5; we1 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("t3_ack", {ack1, ack0}, {(i % 6 == 5), (i % 6 == 2)});
    end
    req0 = 1'b0; req1 = 1'b0;
    check("t3_dout0", dout0, 16'h0006);
    check("t3_dout1", dout1, 16'h0005);
    @(negedge clk);

    // Test 4: address boundaries
    do_access(0, 6'd63, 16'hFFFF, 1'b1);
    do_access(0, 6'd0,  16'h0001, 1'b1);
    do_access(0, 6'd63, 16'h0000, 1'b0);
    check("t4_dout63", dout0, 16'hFFFF);
    do_access(0, 6'd0,  16'h0000, 1'b0);
    check("t4_dout0", dout0, 16'h0001);

    // Test 5: reset during the ACCESS cycle of a write
    do_access(0, 6'd7, 16'h1111, 1'b1);
    req0 = 1'b1; addr0 = 6'd7; din0 = 16'hBEEF; we0 = 1'b1;
    @(negedge clk);
    check("t5_load_pre", mem_load, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t5_load_rst", mem_load, 1'b0);
    check("t5_addr_rst", mem_address, 6'd0);
    req0 = 1'b0;
    @(negedge clk);
    check("t5_noack_a", {ack1, ack0}, 2'b00);
    check("t5_dout0_rst", dout0, 16'h0000);
    reset = 1'b0;
`ifdef RAM64_ARB_CLEAR_EN
    begin
      int n = 0;
      while (busy && n < 200) begin
        n++;
        check("t5_noack_init", {ack1, ack0}, 2'b00);
        @(negedge clk);
      end
      check("t5_busy_cycles", n, 64);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_noack_b", {ack1, ack0}, 2'b00);
    end
    do_access(0, 6'd7, 16'h0000, 1'b0);
`ifdef RAM64_ARB_CLEAR_EN
    check("t5_prior", dout0, 16'h0000);
`else
    check("t5_prior", dout0, 16'h1111);
`endif

`ifdef RAM64_ARB_CLEAR_EN
    // Test 6: request held during the clear sweep, then sweep result
    do_access(0, 6'd31, 16'h5A5A, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; addr0 = 6'd31; we0 = 1'b0;
    begin
      int n = 0;
      while (busy && n < 200) begin
        n++;
        check("t6_held", ack0, 1'b0);
        @(negedge clk);
      end
      check("t6_busy_cycles", n, 64);
    end
    @(negedge clk);
    check("t6_ack_early", ack0, 1'b0);
    @(negedge clk);
    check("t6_ack", ack0, 1'b1);
    req0 = 1'b0;
    check("t6_dout31", dout0, 16'h0000);
    @(negedge clk);
    do_access(0, 6'd63, 16'h0000, 1'b0);
    check("t6_dout63", dout0, 16'h0000);
    do_access(0, 6'd0, 16'h0000, 1'b0);
    check("t6_dout0", dout0, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram64_arbiter.md
Name: ram64_arbiter

Overview:
Two-requester round-robin arbiter and sequencer that shares one ram64 instance (64 x 16-bit, synchronous write, combinational read) between two clients, such as a CPU fetch path and a loader.
- The block owns the RAM's address/in/load pins.
- Each access is a single read or write, completed by a one-cycle ack.
- Read data is returned in a per-requester register.

Parameters:
WIDTH, 16, data width; must equal the ram64 word width.
AWIDTH, 6, address width; must equal the ram64 address width (64 words).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req0  input  1  requester 0 access request; held until ack0.
addr0  input  AWIDTH  requester 0 address.
din0  input  WIDTH  requester 0 write data.
we0  input  1  requester 0: 1 = write, 0 = read.
ack0  output  1  one-cycle completion pulse to requester 0.
dout0  output  WIDTH  requester 0 last read data (registered).
req1, addr1, din1, we1, ack1, dout1: same as above, for requester 1.
mem_address  output  AWIDTH  to ram64 address.
mem_in  output  WIDTH  to ram64 in.
mem_load  output  1  to ram64 load.
mem_out  input  WIDTH  from ram64 out.
busy  output  1  high while the arbiter is unable to accept requests (see Optional Feature).

Behaviour:
- Reset (async, immediate) forces all of the following:
  - state=IDLE (INIT with macro); ack0=ack1=0; dout0=dout1=0.
  - mem_load=0, mem_address=0, mem_in=0.
  - last_grant=1, so requester 0 has priority first.
  - RAM contents are untouched.
- FSM states: IDLE -> ACCESS -> ACK -> IDLE.
- IDLE:
  - No req: stay in IDLE; mem outputs 0.
  - Exactly one req: grant that requester.
  - Both reqs: grant the requester != last_grant.
  - On the edge: latch grant into gnt and last_grant; go to ACCESS.
- ACCESS (1 cycle):
  - mem_address=addr[gnt], mem_in=din[gnt], mem_load=we[gnt]; all combinational from the latched gnt.
  - On the edge: RAM performs any write. If we[gnt]=0, dout[gnt] <= mem_out; dout is unchanged on writes. Go to ACK.
- ACK (1 cycle):
  - ack[gnt]=1 (registered); the other ack stays 0. mem_load=0, mem_address=0.
  - No arbitration occurs in ACK.
  - The requester must drop req or change its fields by the edge that ends ACK. A req still high in the following IDLE is treated as a new request.
- Latency: req seen in IDLE at cycle N -> mem access in N+1 -> ack in N+2. Throughput is 1 access per 3 cycles.
- Requester addr/din/we must be stable from req assertion until ack. Changes during ACCESS are undefined use.
- Address range 0..63 with no wrap logic. Each address maps directly.
- Reset during ACCESS:
  - mem_load falls immediately, so the write is aborted if reset precedes the clock edge.
  - No ack is issued; the requester must re-issue after reset.
- A requester never receives two acks for one req assertion held only until ack.
- busy=0 at all times when the macro is absent.

Optional Feature:
Macro RAM64_ARB_CLEAR_EN.
- Defined:
  - After reset release, the FSM is in INIT: a 6-bit counter sweeps addresses 0..63 with mem_address=cnt, mem_in=0, mem_load=1, one word per cycle, 64 cycles.
  - busy=1 throughout INIT and is reset-high.
  - Requests are ignored (held) during INIT. After cnt=63 is written, go to IDLE with busy=0.
  - Reset mid-sweep restarts the sweep at 0.
- Undefined: no INIT state and no counter; reset goes straight to IDLE; busy is tied 0.

Test Plan:
1. After reset, req0 write addr=3 din=16'h1234, then req0 read addr=3 -> ack0 pulses 2 cycles after each request; dout0=16'h1234 after the read ack; ack1 stays 0.
2. Both requests rise together (req0 read addr=5, req1 read addr=6, RAM preloaded 16'h0005/16'h0006) -> requester 0 served first (ack0 at +2), then requester 1 (ack1 at +5); dout0=5, dout1=6.
3. req0 and req1 held high continuously, each re-issuing after ack -> grants alternate 0,1,0,1; no requester is acked twice in a row.
4. Boundary: write addr=63 din=16'hFFFF, write addr=0 din=16'h0001, read 63 then 0 -> dout=16'hFFFF then 16'h0001; no aliasing.
5. Raise reset during ACCESS of a write to addr=7 din=16'hBEEF, before the clock edge -> mem_load drops immediately; ack never pulses; a later read of 7 returns the prior value.
6. With RAM64_ARB_CLEAR_EN: busy=1 for exactly 64 cycles after reset. A req0 raised during busy is acked 2 cycles after busy falls. Reads of addresses 0, 31 and 63 return 0.
